// File: rtl/note_track_pkg.sv
// Shared types and constants for the falling-note track engine.
package note_track_pkg;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2
  } lane_e;

  // Horizontal pixel windows of the three lanes (inclusive bounds)
  localparam logic [9:0] LANE0_X_LO = 10'd0;
  localparam logic [9:0] LANE0_X_HI = 10'd199;
  localparam logic [9:0] LANE1_X_LO = 10'd220;
  localparam logic [9:0] LANE1_X_HI = 10'd419;
  localparam logic [9:0] LANE2_X_LO = 10'd440;
  localparam logic [9:0] LANE2_X_HI = 10'd639;

  typedef struct packed {
    logic       valid;
    lane_e      lane;
    logic [9:0] y;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SPAWN = 2'd2
  } state_e;

  // True when x falls inside the horizontal window of the given lane
  function automatic logic in_lane_window(input lane_e lane, input logic [9:0] x);
    logic [9:0] lo;
    logic [9:0] hi;
    case (lane)
      LANE0:   begin lo = LANE0_X_LO; hi = LANE0_X_HI; end
      LANE1:   begin lo = LANE1_X_LO; hi = LANE1_X_HI; end
      LANE2:   begin lo = LANE2_X_LO; hi = LANE2_X_HI; end
      default: begin lo = 10'd1;      hi = 10'd0;      end
    endcase
    return (x >= lo) && (x <= hi);
  endfunction

  // Note pattern, {R,G,B} with bit2 = lane0: a chord opener, single
  // lane0 notes, and a rest on the last beat.
  function automatic logic [2:0] pattern_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    return 3'b111;
      4'd15:   return 3'b000;
      default: return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/note_pattern_rom.sv
// Constant note pattern ROM, asynchronous read by beat index.
module note_pattern_rom
  import note_track_pkg::*;
#(
  parameter int unsigned NOTE_LEN = 16
) (
  input  logic [3:0] index,
  output logic [2:0] data
);

  // Entries beyond the pattern length read as rests
  always_comb begin
    data = 3'b000;
    if (32'(index) < NOTE_LEN) data = pattern_entry(index);
  end

endmodule

// File: rtl/note_track_engine.sv
// Steps the note pattern, spawns bars into a slot table, scrolls them and
// answers the VGA scan position with registered per-lane pixel flags.
module note_track_engine
  import note_track_pkg::*;
#(
  parameter int unsigned NSLOTS   = 8,
  parameter int unsigned NOTE_LEN = 16,
  parameter int unsigned Y_SPAWN  = 0,
  parameter int unsigned Y_END    = 479,
  parameter int unsigned STEP     = 1,
  parameter int unsigned BAR_HALF = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       pause,
  input  logic       scroll_tick,
  input  logic       beat_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       lane_r,
  output logic       lane_g,
  output logic       lane_b,
  output logic [3:0] active_cnt,
  output logic [3:0] beat_idx,
  output logic       pattern_done,
  output logic       spawn_ovf
);

  localparam int unsigned SLOT_W = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  slot_t             slots      [NSLOTS];
  slot_t             slots_next [NSLOTS];
  logic              retire     [NSLOTS];
  logic [10:0]       y_adv      [NSLOTS];
  logic              free_any;
  logic [SLOT_W-1:0] alloc_idx;

  state_e     state, state_next;
  logic [2:0] mask, mask_next;
  logic       pending, pending_next;
  logic [3:0] beat_idx_next;
  logic       done_next;
  logic       ovf_next;
  logic       spawn_req;
  lane_e      spawn_lane;
  logic [3:0] cnt_next;
  logic [2:0] rom_data;
  logic [2:0] hit;
  logic [9:0] y_lo;
  logic [10:0] y_hi;

  logic scroll_en;
  logic beat_en;

  assign scroll_en = scroll_tick & ~pause;
  assign beat_en   = beat_tick & ~pause;

  note_pattern_rom #(.NOTE_LEN(NOTE_LEN)) u_rom (
    .index (beat_idx),
    .data  (rom_data)
  );

  // Retire detection and lowest-free-slot priority encoder; a slot retiring
  // this cycle already counts as free so a spawn can reuse it at once
  always_comb begin
    free_any  = 1'b0;
    alloc_idx = '0;
    for (int unsigned i = 0; i < NSLOTS; i++) begin
      y_adv[i]  = {1'b0, slots[i].y} + 11'(STEP);
      retire[i] = scroll_en && slots[i].valid && (y_adv[i] > 11'(Y_END));
      if (!free_any && (!slots[i].valid || retire[i])) begin
        free_any  = 1'b1;
        alloc_idx = SLOT_W'(i);
      end
    end
  end

  // FSM next state, pattern stepping, pending beat and overflow tracking
  always_comb begin
    state_next    = state;
    mask_next     = mask;
    pending_next  = pending;
    beat_idx_next = beat_idx;
    done_next     = 1'b0;
    ovf_next      = spawn_ovf;
    spawn_req     = 1'b0;
    spawn_lane    = LANE0;
    case (state)
      ST_IDLE: begin
        if (beat_en || (pending && !pause)) begin
          state_next = ST_FETCH;
          // a fresh tick arriving while a queued one is served stays queued
          pending_next = beat_en && pending;
        end
      end
      ST_FETCH: begin
        mask_next  = rom_data;
        state_next = ST_SPAWN;
        if (beat_idx == 4'(NOTE_LEN - 1)) begin
          beat_idx_next = '0;
          done_next     = 1'b1;
        end else begin
          beat_idx_next = beat_idx + 4'd1;
        end
      end
      ST_SPAWN: begin
        if (mask[2]) begin
          spawn_req  = 1'b1;
          spawn_lane = LANE0;
          mask_next  = {1'b0, mask[1:0]};
        end else if (mask[1]) begin
          spawn_req  = 1'b1;
          spawn_lane = LANE1;
          mask_next  = {2'b00, mask[0]};
        end else if (mask[0]) begin
          spawn_req  = 1'b1;
          spawn_lane = LANE2;
          mask_next  = 3'b000;
        end
        if (mask_next == 3'b000) state_next = ST_IDLE;
        if (spawn_req && !free_any) ovf_next = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
    if (state != ST_IDLE && beat_en) begin
      if (pending) ovf_next = 1'b1;
      else         pending_next = 1'b1;
    end
  end

  // Next slot table: scroll/retire, then allocation overrides the same slot
  always_comb begin
    cnt_next = '0;
    for (int unsigned i = 0; i < NSLOTS; i++) begin
      slots_next[i] = slots[i];
      if (scroll_en && slots[i].valid) begin
        if (retire[i]) slots_next[i].valid = 1'b0;
        else           slots_next[i].y     = y_adv[i][9:0];
      end
      if (spawn_req && free_any && (alloc_idx == SLOT_W'(i))) begin
        slots_next[i] = '{valid: 1'b1, lane: spawn_lane, y: 10'(Y_SPAWN)};
      end
      cnt_next = cnt_next + {3'b000, slots_next[i].valid};
    end
  end

  // Per-lane OR of vertical-span and lane-window hits; span clamps at row 0
  always_comb begin
    hit  = 3'b000;
    y_lo = '0;
    y_hi = '0;
    for (int unsigned i = 0; i < NSLOTS; i++) begin
      y_lo = (slots[i].y >= 10'(BAR_HALF)) ? (slots[i].y - 10'(BAR_HALF)) : 10'd0;
      y_hi = {1'b0, slots[i].y} + 11'(BAR_HALF);
      if (slots[i].valid && in_lane_window(slots[i].lane, pixel_x) &&
          (pixel_y >= y_lo) && ({1'b0, pixel_y} <= y_hi)) begin
        case (slots[i].lane)
          LANE0:   hit[0] = 1'b1;
          LANE1:   hit[1] = 1'b1;
          LANE2:   hit[2] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n || !run) state <= ST_IDLE;
    else                  state <= state_next;
  end

  // Slot table, pattern position and status registers
  always_ff @(posedge clk) begin
    if (!reset_n || !run) begin
      for (int unsigned i = 0; i < NSLOTS; i++) slots[i] <= '0;
      mask         <= '0;
      pending      <= 1'b0;
      beat_idx     <= '0;
      pattern_done <= 1'b0;
      active_cnt   <= '0;
    end else begin
      for (int unsigned i = 0; i < NSLOTS; i++) slots[i] <= slots_next[i];
      mask         <= mask_next;
      pending      <= pending_next;
      beat_idx     <= beat_idx_next;
      pattern_done <= done_next;
      active_cnt   <= cnt_next;
    end
  end

  // Sticky overflow flag survives run toggles
  always_ff @(posedge clk) begin
    if (!reset_n)  spawn_ovf <= 1'b0;
    else if (run)  spawn_ovf <= ovf_next;
  end

  // Registered pixel flags
  always_ff @(posedge clk) begin
    if (!reset_n || !run) begin
      lane_r <= 1'b0;
      lane_g <= 1'b0;
      lane_b <= 1'b0;
    end else begin
      lane_r <= hit[0];
      lane_g <= hit[1];
      lane_b <= hit[2];
    end
  end

endmodule

// File: tb/tb_note_track_engine.sv
// Directed, table-driven bench for note_track_engine.
module tb_note_track_engine;

  logic       clk = 1'b0;
  logic       reset_n, run, pause, scroll_tick, beat_tick;
  logic [9:0] pixel_x, pixel_y;
  logic       lane_r, lane_g, lane_b;
  logic [3:0] active_cnt, beat_idx;
  logic       pattern_done, spawn_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] rgb;
  } pix_vec_t;

  pix_vec_t vecs [15];

  note_track_engine #(
    .NSLOTS(8), .NOTE_LEN(16), .Y_SPAWN(0), .Y_END(479), .STEP(1), .BAR_HALF(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .pause(pause),
    .scroll_tick(scroll_tick), .beat_tick(beat_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .lane_r(lane_r), .lane_g(lane_g), .lane_b(lane_b),
    .active_cnt(active_cnt), .beat_idx(beat_idx),
    .pattern_done(pattern_done), .spawn_ovf(spawn_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pattern_done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [2:0] exp,
                     input string name);
    pixel_x = x;
    pixel_y = y;
    tick();
    check(name, 32'({lane_r, lane_g, lane_b}), 32'(exp));
  endtask

  task automatic beat();
    beat_tick = 1'b1;
    tick();
    beat_tick = 1'b0;
    repeat (7) tick();
  endtask

  task automatic scroll(input int n);
    scroll_tick = 1'b1;
    repeat (n) tick();
    scroll_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // bars sit at y=100 in all three lanes when this table is applied
    vecs[0]  = '{10'd50,  10'd110, 3'b100};
    vecs[1]  = '{10'd50,  10'd111, 3'b000};
    vecs[2]  = '{10'd50,  10'd89,  3'b000};
    vecs[3]  = '{10'd50,  10'd90,  3'b100};
    vecs[4]  = '{10'd250, 10'd100, 3'b010};
    vecs[5]  = '{10'd199, 10'd100, 3'b100};
    vecs[6]  = '{10'd200, 10'd100, 3'b000};
    vecs[7]  = '{10'd219, 10'd100, 3'b000};
    vecs[8]  = '{10'd220, 10'd100, 3'b010};
    vecs[9]  = '{10'd419, 10'd95,  3'b010};
    vecs[10] = '{10'd420, 10'd100, 3'b000};
    vecs[11] = '{10'd440, 10'd95,  3'b001};
    vecs[12] = '{10'd639, 10'd105, 3'b001};
    vecs[13] = '{10'd640, 10'd100, 3'b000};
    vecs[14] = '{10'd700, 10'd100, 3'b000};

    reset_n = 1'b0; run = 1'b1; pause = 1'b0;
    scroll_tick = 1'b0; beat_tick = 1'b0;
    pixel_x = 10'd50; pixel_y = 10'd0;
    repeat (2) tick();
    check("rst_lanes", 32'({lane_r, lane_g, lane_b}), 32'd0);
    check("rst_cnt", 32'(active_cnt), 32'd0);
    check("rst_idx", 32'(beat_idx), 32'd0);
    check("rst_done", 32'(pattern_done), 32'd0);
    check("rst_ovf", 32'(spawn_ovf), 32'd0);
    reset_n = 1'b1;
    tick();

    // chord beat: one slot per cycle after FETCH
    beat_tick = 1'b1;
    tick();
    beat_tick = 1'b0;
    tick();
    check("fetch_cnt", 32'(active_cnt), 32'd0);
    check("fetch_idx", 32'(beat_idx), 32'd1);
    tick();
    check("spawn_cnt1", 32'(active_cnt), 32'd1);
    tick();
    check("spawn_cnt2", 32'(active_cnt), 32'd2);
    tick();
    check("spawn_cnt3", 32'(active_cnt), 32'd3);
    repeat (3) tick();
    check("spawn_cnt_hold", 32'(active_cnt), 32'd3);

    pix(10'd100, 10'd0,  3'b100, "y0_lane0");
    pix(10'd300, 10'd10, 3'b010, "y0_lane1");
    pix(10'd500, 10'd10, 3'b001, "y0_lane2");
    pix(10'd100, 10'd11, 3'b000, "y0_below");

    // bars at y=5: top of span clamps at row 0, no wrap near 1023
    scroll(5);
    pix(10'd50, 10'd0,    3'b100, "y5_row0");
    pix(10'd50, 10'd1020, 3'b000, "y5_ghost");
    pix(10'd50, 10'd15,   3'b100, "y5_bottom");
    pix(10'd50, 10'd16,   3'b000, "y5_past");

    scroll(95);
    foreach (vecs[i]) pix(vecs[i].x, vecs[i].y, vecs[i].rgb, $sformatf("tbl%0d", i));

    // pause: ticks ignored, state held
    pause = 1'b1;
    scroll_tick = 1'b1;
    for (int i = 0; i < 50; i++) begin
      beat_tick = (i % 5 == 0);
      tick();
    end
    scroll_tick = 1'b0;
    beat_tick = 1'b0;
    tick();
    pause = 1'b0;
    tick();
    check("pause_idx", 32'(beat_idx), 32'd1);
    check("pause_cnt", 32'(active_cnt), 32'd3);
    pix(10'd50, 10'd110, 3'b100, "pause_y_in");
    pix(10'd50, 10'd111, 3'b000, "pause_y_out");

    // single lane0 beat, then scroll the older bars to the retire point
    beat();
    check("b1_cnt", 32'(active_cnt), 32'd4);
    check("b1_idx", 32'(beat_idx), 32'd2);
    scroll(379);
    check("y479_cnt", 32'(active_cnt), 32'd4);
    pix(10'd300, 10'd489, 3'b010, "y479_span");
    pix(10'd50,  10'd369, 3'b100, "y379_top");
    scroll(1);
    check("retire_cnt", 32'(active_cnt), 32'd1);
    pix(10'd300, 10'd479, 3'b000, "retired_g");
    pix(10'd50,  10'd390, 3'b100, "survivor");

    // fill the table, then overflow
    do_reset();
    repeat (6) beat();
    check("full_cnt", 32'(active_cnt), 32'd8);
    check("full_ovf", 32'(spawn_ovf), 32'd0);
    check("full_idx", 32'(beat_idx), 32'd6);
    beat();
    check("ovf_cnt", 32'(active_cnt), 32'd8);
    check("ovf_set", 32'(spawn_ovf), 32'd1);
    run = 1'b0;
    tick();
    check("runclr_cnt", 32'(active_cnt), 32'd0);
    check("runclr_idx", 32'(beat_idx), 32'd0);
    check("runclr_ovf", 32'(spawn_ovf), 32'd1);
    run = 1'b1;
    tick();
    check("run_ovf_keep", 32'(spawn_ovf), 32'd1);
    reset_n = 1'b0;
    tick();
    check("rst_ovf_clr", 32'(spawn_ovf), 32'd0);
    reset_n = 1'b1;
    tick();

    // three consecutive beat ticks: served, pending, dropped
    beat_tick = 1'b1;
    repeat (3) tick();
    beat_tick = 1'b0;
    repeat (12) tick();
    check("pend_cnt", 32'(active_cnt), 32'd4);
    check("pend_idx", 32'(beat_idx), 32'd2);
    check("pend_ovf", 32'(spawn_ovf), 32'd1);

    // full pattern pass
    do_reset();
    done_cnt = 0;
    repeat (15) beat();
    check("pre_wrap_done", 32'(done_cnt), 32'd0);
    check("pre_wrap_idx", 32'(beat_idx), 32'd15);
    beat();
    check("wrap_done", 32'(done_cnt), 32'd1);
    check("wrap_idx", 32'(beat_idx), 32'd0);
    check("wrap_cnt", 32'(active_cnt), 32'd8);

    // reset in the middle of a spawn sequence
    do_reset();
    pixel_x = 10'd50;
    pixel_y = 10'd0;
    beat_tick = 1'b1;
    tick();
    beat_tick = 1'b0;
    tick();
    tick();
    check("mid_cnt", 32'(active_cnt), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_cnt", 32'(active_cnt), 32'd0);
    check("mid_rst_idx", 32'(beat_idx), 32'd0);
    check("mid_rst_lanes", 32'({lane_r, lane_g, lane_b}), 32'd0);
    check("mid_rst_done", 32'(pattern_done), 32'd0);
    check("mid_rst_ovf", 32'(spawn_ovf), 32'd0);
    reset_n = 1'b1;
    repeat (4) tick();
    check("mid_after_cnt", 32'(active_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
